// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: slave-select setup, SCLK edge counting, hold, completion.
// Optional sticky interrupt enabled by defining SPI_XFER_IRQ_EN (default build: irq tied low).
module spi_xfer_ctrl #(
  parameter int CHAR_LEN_W = 7,
  parameter int SS_NB      = 8,
  parameter int DIV_W      = 16
) (
  input  logic                  wb_clk_in,
  input  logic                  wb_rst_n,
  input  logic                  go,
  input  logic                  abort,
  input  logic [CHAR_LEN_W-1:0] char_len,
  input  logic [DIV_W-1:0]      divider_in,
  input  logic [SS_NB-1:0]      ss_sel,
  input  logic                  auto_ss,
  input  logic [3:0]            ss_dly,
  input  logic                  cpol_0,
  input  logic                  cpol_1,
  input  logic                  ie,
  input  logic                  irq_ack,
  output logic                  tip,
  output logic                  last_clk,
  output logic [DIV_W-1:0]      divider,
  output logic [SS_NB-1:0]      ss_pad_o,
  output logic                  busy,
  output logic                  done,
  output logic                  irq,
  output logic [1:0]            dbg_state
);

  localparam int EC_W = CHAR_LEN_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, XFER = 2'd2, HOLD = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [EC_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic              ran_q, ran_d;
  logic [3:0]        dly_q, dly_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DIV_W-1:0]  divider_q, divider_d;
  logic              tip_q, tip_d;
  logic              last_clk_q, last_clk_d;
  logic              done_q, done_d;
  logic [SS_NB-1:0]  ss_q, ss_d;

  always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      ran_q      <= 1'b0;
      dly_q      <= '0;
      cnt_q      <= '0;
      divider_q  <= '0;
      tip_q      <= 1'b0;
      last_clk_q <= 1'b0;
      done_q     <= 1'b0;
      ss_q       <= '1;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      ran_q      <= ran_d;
      dly_q      <= dly_d;
      cnt_q      <= cnt_d;
      divider_q  <= divider_d;
      tip_q      <= tip_d;
      last_clk_q <= last_clk_d;
      done_q     <= done_d;
      ss_q       <= ss_d;
    end
  end

  // char_len==0 loads 0, which the counter reaches again only after 2^EC_W edges;
  // ran_q distinguishes that final zero from the freshly loaded one.
  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    ran_d      = ran_q;
    dly_d      = dly_q;
    cnt_d      = cnt_q;
    divider_d  = divider_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (go && !abort) begin
          divider_d  = divider_in;
          edge_cnt_d = {char_len, 1'b0};
          ran_d      = 1'b0;
          dly_d      = ss_dly;
          cnt_d      = ss_dly;
          state_d    = (ss_dly != 4'd0) ? SETUP : XFER;
        end
      end
      SETUP: begin
        if (cnt_q <= 4'd1) state_d = XFER;
        else               cnt_d   = cnt_q - 4'd1;
      end
      XFER: begin
        if (ran_q && edge_cnt_q == '0) begin
          cnt_d = dly_q;
          if (dly_q != 4'd0) begin
            state_d = HOLD;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (cpol_0 || cpol_1) begin
          edge_cnt_d = edge_cnt_q - EC_W'(1);
          ran_d      = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d    = IDLE;
      edge_cnt_d = '0;
      ran_d      = 1'b0;
      done_d     = 1'b0;
    end
    // Outputs are registered from next-state values so they line up with state_q.
    tip_d      = (state_d == XFER);
    last_clk_d = tip_d && (edge_cnt_d == EC_W'(1));
    ss_d       = (!auto_ss || state_d != IDLE) ? ~ss_sel : '1;
  end

`ifdef SPI_XFER_IRQ_EN
  logic irq_q, irq_d;

  // Set covers both the edge that raises done and the done cycle itself, so an
  // acknowledge coinciding with a new completion never loses it.
  always_comb begin
    irq_d = irq_q;
    if (ie && (done_d || done_q)) irq_d = 1'b1;
    else if (irq_ack)             irq_d = 1'b0;
  end

  always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
    if (!wb_rst_n) irq_q <= 1'b0;
    else           irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ie ^ irq_ack;
  assign irq = 1'b0;
`endif

  assign tip       = tip_q;
  assign last_clk  = last_clk_q;
  assign divider   = divider_q;
  assign ss_pad_o  = ss_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a small SCLK generator model driving cpol_0/cpol_1.
module tb_spi_xfer_ctrl;

  logic        clk;
  logic        rst_n;
  logic        go, abort, auto_ss, cpol_0, cpol_1, ie, irq_ack;
  logic [6:0]  char_len;
  logic [15:0] divider_in;
  logic [7:0]  ss_sel;
  logic [3:0]  ss_dly;
  logic        tip, last_clk, busy, done, irq;
  logic [15:0] divider;
  logic [7:0]  ss_pad_o;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  int r, f, tc, pre, post, dn, ab_done;
  logic lc_rise;

  spi_xfer_ctrl #(.CHAR_LEN_W(7), .SS_NB(8), .DIV_W(16)) dut (
    .wb_clk_in(clk), .wb_rst_n(rst_n), .go(go), .abort(abort),
    .char_len(char_len), .divider_in(divider_in), .ss_sel(ss_sel),
    .auto_ss(auto_ss), .ss_dly(ss_dly), .cpol_0(cpol_0), .cpol_1(cpol_1),
    .ie(ie), .irq_ack(irq_ack), .tip(tip), .last_clk(last_clk),
    .divider(divider), .ss_pad_o(ss_pad_o), .busy(busy), .done(done),
    .irq(irq), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SCLK generator model: toggles every divider+1 cycles while tip; last_clk blocks a rising toggle
  logic        sclk;
  logic [15:0] ccnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk <= 1'b0;
      ccnt <= '0;
    end else if (!tip) begin
      sclk <= 1'b0;
      ccnt <= '0;
    end else if (ccnt == divider) begin
      ccnt <= '0;
      if (!last_clk || sclk) sclk <= ~sclk;
    end else begin
      ccnt <= ccnt + 16'd1;
    end
  end
  assign cpol_0 = tip && (ccnt == divider) && !sclk && !last_clk;
  assign cpol_1 = tip && (ccnt == divider) && sclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: present a start at a negedge, return at the negedge of the first cycle after accept
  task automatic start_xfer(input logic [6:0] cl, input logic [15:0] dv, input logic [3:0] d,
                            input bit keep_go);
    int bits;
    char_len   = cl;
    divider_in = dv;
    ss_dly     = d;
    go         = 1'b1;
    bits = (cl == 7'd0) ? 128 : int'(cl);
    exp_q.push_back(16'(2 * bits));
    @(negedge clk);
    if (!keep_go) go = 1'b0;
  endtask

  task automatic monitor_xfer(input int limit, input int go_rel);
    logic prev;
    bit fin;
    logic [15:0] exp_edges;
    r = 0; f = 0; tc = 0; pre = 0; post = 0; dn = 0; lc_rise = 1'b0;
    prev = sclk;
    fin = 1'b0;
    for (int i = 0; i < limit && !fin; i++) begin
      if (i == go_rel) go = 1'b0;
      if (sclk && !prev) begin
        if (r == 0) lc_rise = last_clk;
        r++;
      end
      if (!sclk && prev) f++;
      prev = sclk;
      if (tip) tc++;
      else if (ss_pad_o != 8'hFF) begin
        if (tc == 0) pre++;
        else         post++;
      end
      if (done) dn++;
      if (!busy) fin = 1'b1;
      else       @(negedge clk);
    end
    if (!fin) check("xfer_timeout", 32'd0, 32'd1);
    exp_edges = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
    check("edges_total", 32'(r + f), 32'(exp_edges));
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; abort = 1'b0; char_len = '0; divider_in = '0;
    ss_sel = 8'h01; auto_ss = 1'b1; ss_dly = '0; ie = 1'b1; irq_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tip", 32'(tip), 0);
    check("rst_last_clk", 32'(last_clk), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_divider", 32'(divider), 0);
    check("rst_ss", 32'(ss_pad_o), 32'hFF);
    check("rst_state", 32'(dbg_state), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic: 8 bits, divider 1, no delay
    start_xfer(7'd8, 16'd1, 4'd0, 1'b0);
    check("basic_ss_on", 32'(ss_pad_o), 32'hFE);
    check("basic_tip_on", 32'(tip), 1);
    check("basic_busy_on", 32'(busy), 1);
    check("basic_divider", 32'(divider), 1);
    monitor_xfer(200, -1);
    check("basic_rise", 32'(r), 8);
    check("basic_fall", 32'(f), 8);
    check("basic_tip_len", 32'(tc), 33);
    check("basic_done", 32'(dn), 1);
    check("basic_lc_first_rise", 32'(lc_rise), 0);
    check("basic_ss_off", 32'(ss_pad_o), 32'hFF);
`ifdef SPI_XFER_IRQ_EN
    check("irq_with_done", 32'(irq), 1);
`else
    check("irq_with_done", 32'(irq), 0);
`endif
    @(negedge clk);
    check("basic_done_single", 32'(done), 0);
    repeat (3) @(negedge clk);
`ifdef SPI_XFER_IRQ_EN
    check("irq_held", 32'(irq), 1);
`else
    check("irq_held", 32'(irq), 0);
`endif

    // setup/hold delays, single bit
    start_xfer(7'd1, 16'd1, 4'd3, 1'b0);
    check("dly_ss_on", 32'(ss_pad_o), 32'hFE);
    check("dly_tip_off", 32'(tip), 0);
    monitor_xfer(200, -1);
    check("dly_pre", 32'(pre), 3);
    check("dly_post", 32'(post), 3);
    check("dly_tip_len", 32'(tc), 5);
    check("dly_rise", 32'(r), 1);
    check("dly_fall", 32'(f), 1);
    check("dly_lc_after_rise", 32'(lc_rise), 1);
    check("dly_done", 32'(dn), 1);

    // ack coinciding with a new completion, then a lone ack
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
`ifdef SPI_XFER_IRQ_EN
    check("irq_ack_vs_set", 32'(irq), 1);
`else
    check("irq_ack_vs_set", 32'(irq), 0);
`endif
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    check("irq_cleared", 32'(irq), 0);

    // maximum length: char_len 0 -> 128 bits
    start_xfer(7'd0, 16'd1, 4'd0, 1'b0);
    monitor_xfer(2000, -1);
    check("max_rise", 32'(r), 128);
    check("max_fall", 32'(f), 128);
    check("max_tip_len", 32'(tc), 513);
    check("max_done", 32'(dn), 1);
    check("max_idle", 32'(dbg_state), 0);

    // go held through part of XFER is not re-accepted
    start_xfer(7'd8, 16'd1, 4'd0, 1'b1);
    monitor_xfer(200, 12);
    check("hold_go_rise", 32'(r), 8);
    check("hold_go_fall", 32'(f), 8);
    check("hold_go_tip_len", 32'(tc), 33);
    check("hold_go_done", 32'(dn), 1);
    @(negedge clk);
    check("hold_go_idle", 32'(busy), 0);

    // abort mid-XFER
    start_xfer(7'd8, 16'd1, 4'd0, 1'b0);
    repeat (10) @(negedge clk);
    abort = 1'b1;
    go    = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    go    = 1'b0;
    exp_q.delete();
    check("abort_busy", 32'(busy), 0);
    check("abort_tip", 32'(tip), 0);
    check("abort_last_clk", 32'(last_clk), 0);
    check("abort_ss", 32'(ss_pad_o), 32'hFF);
    ab_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) ab_done++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(ab_done), 0);

    // auto_ss off: SS follows ss_sel while idle
    auto_ss = 1'b0;
    ss_sel  = 8'h05;
    repeat (2) @(negedge clk);
    check("manual_ss", 32'(ss_pad_o), 32'hFA);
    auto_ss = 1'b1;
    ss_sel  = 8'h80;
    repeat (2) @(negedge clk);
    check("auto_ss_idle", 32'(ss_pad_o), 32'hFF);

    // asynchronous reset mid-XFER, then a full transfer
    start_xfer(7'd8, 16'd1, 4'd0, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tip", 32'(tip), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_ss", 32'(ss_pad_o), 32'hFF);
    check("arst_divider", 32'(divider), 0);
    check("arst_last_clk", 32'(last_clk), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_xfer(7'd8, 16'd2, 4'd0, 1'b0);
    check("post_rst_ss", 32'(ss_pad_o), 32'h7F);
    monitor_xfer(300, -1);
    check("post_rst_rise", 32'(r), 8);
    check("post_rst_fall", 32'(f), 8);
    check("post_rst_tip_len", 32'(tc), 49);
    check("post_rst_done", 32'(dn), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
